pattern_entry_conditioner: RTL and testbench

Input front end for the secure lock. It turns four raw slide switches and two raw push-buttons (ENTER, CLEAR) into a clean, synchronized 4-bit pattern with a one-cycle `pattern_valid` strobe, so the lock sequence FSM sees exactly one symbol per button press. It also flags abandoned entry sequences with an inactivity timeout pulse.

---
 rtl/pattern_entry_conditioner_if.sv | 22 ++
 rtl/pattern_entry_conditioner.sv | 133 +++++++++++++
 tb/tb_pattern_entry_conditioner.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pattern_entry_conditioner_if.sv
// Raw switch/button inputs and the conditioned symbol outputs of the lock front end.
// The producer of raw levels uses master; the conditioner itself uses slave.
interface pattern_entry_conditioner_if;
    logic [3:0] sw_raw;
    logic       btn_enter_raw;
    logic       btn_clear_raw;
    logic [3:0] pattern_out;
    logic       pattern_valid;
    logic       clear_pulse;
    logic       entry_timeout;
    logic       armed;

    modport master (
        output sw_raw, btn_enter_raw, btn_clear_raw,
        input  pattern_out, pattern_valid, clear_pulse, entry_timeout, armed
    );

    modport slave (
        input  sw_raw, btn_enter_raw, btn_clear_raw,
        output pattern_out, pattern_valid, clear_pulse, entry_timeout, armed
    );
endinterface

// File: rtl/pattern_entry_conditioner.sv
// Synchronizes and debounces the lock switches/buttons, emits one pattern strobe per
// ENTER press, a strobe per CLEAR press, and an inactivity timeout for abandoned entries.
module pattern_entry_conditioner #(
    parameter int unsigned DB_CYCLES      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic                        clk,
    input logic                        rst,
    pattern_entry_conditioner_if.slave bus
);
    localparam int unsigned DBW = $clog2(DB_CYCLES + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ARMED = 1'b1;

    // Bit order: [5] CLEAR, [4] ENTER, [3:0] switches.
    logic [5:0]     raw;
    logic [5:0]     sync1_q, sync2_q;
    logic [5:0]     stable_q;
    logic [DBW-1:0] db_cnt_q [6];
    logic [1:0]     btn_prev_q;

    logic           enter_rise, clear_rise;
    logic [3:0]     pattern_d, pattern_q;
    logic           pattern_valid_d, pattern_valid_q;
    logic           clear_pulse_d, clear_pulse_q;
    logic           timeout_d, timeout_q;
    logic [0:0]     state_d, state_q;
    logic [TW-1:0]  idle_cnt_d, idle_cnt_q;

    assign raw = {bus.btn_clear_raw, bus.btn_enter_raw, bus.sw_raw};

    // NOTE: state is updated with non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours, exactly like the hardware it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            db_cnt_q   <= '{default: '0};
            btn_prev_q <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            btn_prev_q <= stable_q[5:4];
            for (int i = 0; i < 6; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    stable_q[i] <= ~stable_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        enter_rise      = stable_q[4] & ~btn_prev_q[0];
        clear_rise      = stable_q[5] & ~btn_prev_q[1];
        clear_pulse_d   = clear_rise;
        pattern_valid_d = enter_rise & ~clear_rise;
        pattern_d       = pattern_q;
        if (clear_rise)
            pattern_d = 4'b0000;
        else if (enter_rise)
            pattern_d = stable_q[3:0];
    end

    // The FSM reacts to the next-cycle strobes so armed rises together with pattern_valid
    // and the timeout lands exactly TIMEOUT_CYCLES after the strobe cycle.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pattern_valid_d) begin
                    state_d    = ARMED;
                    idle_cnt_d = '0;
                end
            end
            ARMED: begin
                if (pattern_valid_d) begin
                    idle_cnt_d = '0;
                end else if (clear_pulse_d) begin
                    state_d    = IDLE;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == TMO_LAST) begin
                    timeout_d  = 1'b1;
                    state_d    = IDLE;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + TW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                idle_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_q       <= '0;
            pattern_valid_q <= 1'b0;
            clear_pulse_q   <= 1'b0;
            timeout_q       <= 1'b0;
            state_q         <= IDLE;
            idle_cnt_q      <= '0;
        end else begin
            pattern_q       <= pattern_d;
            pattern_valid_q <= pattern_valid_d;
            clear_pulse_q   <= clear_pulse_d;
            timeout_q       <= timeout_d;
            state_q         <= state_d;
            idle_cnt_q      <= idle_cnt_d;
        end
    end

    assign bus.pattern_out   = pattern_q;
    assign bus.pattern_valid = pattern_valid_q;
    assign bus.clear_pulse   = clear_pulse_q;
    assign bus.entry_timeout = timeout_q;
    assign bus.armed         = (state_q == ARMED);
endmodule

// File: tb/tb_pattern_entry_conditioner.sv
// Directed bench for pattern_entry_conditioner with DB_CYCLES=4, TIMEOUT_CYCLES=32:
// press latency, bounce rejection, CLEAR priority, timeout, re-arm and reset mid-debounce.
module tb_pattern_entry_conditioner;
    localparam int DB  = 4;
    localparam int TMO = 32;
    localparam int LAT = DB + 3;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pv_cnt   = 0;
    int   cp_cnt   = 0;
    int   to_cnt   = 0;

    pattern_entry_conditioner_if bus ();

    pattern_entry_conditioner #(
        .DB_CYCLES      (DB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tallies let the bench prove "exactly one" / "none" over a window.
    always @(negedge clk) begin
        if (!rst) begin
            pv_cnt <= pv_cnt + int'(bus.pattern_valid);
            cp_cnt <= cp_cnt + int'(bus.clear_pulse);
            to_cnt <= to_cnt + int'(bus.entry_timeout);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " pattern_out"},   32'(bus.pattern_out),   32'h0);
        check({tag, " pattern_valid"}, 32'(bus.pattern_valid), 32'h0);
        check({tag, " clear_pulse"},   32'(bus.clear_pulse),   32'h0);
        check({tag, " entry_timeout"}, 32'(bus.entry_timeout), 32'h0);
        check({tag, " armed"},         32'(bus.armed),         32'h0);
    endtask

    // Raise ENTER right after an edge; the next edge is edge 1, the strobe follows edge LAT.
    task automatic press_and_check(input string tag, input int hold, input int low);
        bus.btn_enter_raw = 1'b1;
        for (int i = 1; i < LAT; i++) begin
            step();
            check({tag, " no early strobe"}, 32'(bus.pattern_valid), 32'h0);
        end
        step();
        check({tag, " strobe"}, 32'(bus.pattern_valid), 32'h1);
        check({tag, " armed"},  32'(bus.armed),         32'h1);
        repeat (hold - LAT) step();
        bus.btn_enter_raw = 1'b0;
        repeat (low) step();
    endtask

    int pv0, to0, cp0;

    initial begin
        rst               = 1'b1;
        bus.sw_raw        = 4'b0000;
        bus.btn_enter_raw = 1'b0;
        bus.btn_clear_raw = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) step();

        // Clean press, then idle until the timeout.
        pv0 = pv_cnt; to0 = to_cnt;
        bus.sw_raw        = 4'b0011;
        bus.btn_enter_raw = 1'b1;
        for (int i = 1; i < LAT; i++) begin
            step();
            check("clean no early strobe", 32'(bus.pattern_valid), 32'h0);
        end
        step();
        check("clean strobe",      32'(bus.pattern_valid), 32'h1);
        check("clean pattern_out", 32'(bus.pattern_out),   32'h3);
        check("clean armed",       32'(bus.armed),         32'h1);
        for (int k = 1; k < TMO; k++) begin
            step();
            if (k == 20 - LAT) bus.btn_enter_raw = 1'b0;
            check("timeout not early", 32'(bus.entry_timeout), 32'h0);
        end
        step();
        check("timeout pulse", 32'(bus.entry_timeout), 32'h1);
        check("timeout armed", 32'(bus.armed),         32'h0);
        step();
        check("timeout one cycle", 32'(bus.entry_timeout), 32'h0);
        repeat (100) step();
        check("clean single strobe",  32'(pv_cnt - pv0), 32'h1);
        check("single timeout pulse", 32'(to_cnt - to0), 32'h1);
        check("held pattern_out",     32'(bus.pattern_out), 32'h3);

        // Bounce rejection: 1-, 2-, 3-cycle pulses then a steady hold.
        pv0 = pv_cnt;
        bus.sw_raw = 4'b1010;
        bus.btn_enter_raw = 1'b1; step();
        bus.btn_enter_raw = 1'b0; repeat (2) step();
        bus.btn_enter_raw = 1'b1; repeat (2) step();
        bus.btn_enter_raw = 1'b0; repeat (2) step();
        bus.btn_enter_raw = 1'b1; repeat (3) step();
        bus.btn_enter_raw = 1'b0; repeat (2) step();
        check("bounce no strobe", 32'(pv_cnt - pv0), 32'h0);
        press_and_check("bounce", 12, 10);
        check("bounce single strobe", 32'(pv_cnt - pv0),     32'h1);
        check("bounce pattern_out",   32'(bus.pattern_out),  32'ha);

        // ENTER and CLEAR together: CLEAR wins and disarms.
        pv0 = pv_cnt; cp0 = cp_cnt;
        bus.sw_raw        = 4'b0101;
        bus.btn_enter_raw = 1'b1;
        bus.btn_clear_raw = 1'b1;
        repeat (LAT - 1) step();
        check("prio no early clear", 32'(bus.clear_pulse), 32'h0);
        step();
        check("prio clear_pulse",   32'(bus.clear_pulse),   32'h1);
        check("prio no strobe",     32'(bus.pattern_valid), 32'h0);
        check("prio pattern_out",   32'(bus.pattern_out),   32'h0);
        check("prio armed",         32'(bus.armed),         32'h0);
        repeat (10) step();
        bus.btn_enter_raw = 1'b0;
        bus.btn_clear_raw = 1'b0;
        repeat (10) step();
        check("prio single clear",  32'(cp_cnt - cp0), 32'h1);
        check("prio no strobes",    32'(pv_cnt - pv0), 32'h0);

        // Re-arm: four presses 20 cycles apart keep the session alive.
        pv0 = pv_cnt; to0 = to_cnt;
        bus.sw_raw = 4'b0110;
        for (int p = 0; p < 4; p++) begin
            press_and_check("rearm", 8, 12);
            check("rearm still armed", 32'(bus.armed), 32'h1);
        end
        check("rearm four strobes", 32'(pv_cnt - pv0), 32'h4);
        check("rearm pattern_out",  32'(bus.pattern_out), 32'h6);
        // 13 cycles have passed since the 4th strobe.
        for (int k = 20 - LAT + 1; k < TMO; k++) begin
            step();
            check("rearm timeout not early", 32'(bus.entry_timeout), 32'h0);
        end
        step();
        check("rearm timeout pulse",  32'(bus.entry_timeout), 32'h1);
        check("rearm timeout count",  32'(to_cnt - to0),      32'h0);
        repeat (3) step();

        // Reset in the middle of a debounce count.
        bus.btn_enter_raw = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        #1;
        check_all_zero("mid reset async");
        repeat (2) step();
        check_all_zero("mid reset held");
        rst = 1'b0;
        press_and_check("after reset", 10, 8);
        check("after reset pattern", 32'(bus.pattern_out), 32'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
